// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver with make/break tracking.
// Presents each valid scan-code byte with a one-cycle strobe and drives a key-held LED.
module ps2_keyboard_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [7:0]  BREAK_CODE     = 8'hF0
) (
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       CLK,
    input  logic       reset,
    output logic       LED,
    output logic [7:0] data_out,
    output logic       new_code
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

    state_e            state_q;
    logic              clk_s1_q, clk_s2_q, clk_prev_q;
    logic              dat_s1_q, dat_s2_q;
    logic [3:0]        cnt_q;
    logic [9:0]        shift_q;
    logic [TmoW-1:0]   tmo_q;
    logic              brk_q;
    logic              led_q;
    logic              new_code_q;
    logic [7:0]        data_q;
    logic              fall;

    assign fall = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= StIdle;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            cnt_q      <= 4'd0;
            shift_q    <= 10'd0;
            tmo_q      <= '0;
            brk_q      <= 1'b0;
            led_q      <= 1'b0;
            new_code_q <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_DATA;
            dat_s2_q   <= dat_s1_q;
            new_code_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= 4'd0;
                    tmo_q <= '0;
                    if (fall && !dat_s2_q) begin
                        cnt_q   <= 4'd1;
                        state_q <= StRecv;
                    end
                end
                StRecv: begin
                    if (fall) begin
                        tmo_q   <= '0;
                        // After ten shifts: [7:0]=D0..D7, [8]=parity, [9]=stop.
                        shift_q <= {dat_s2_q, shift_q[9:1]};
                        if (cnt_q == 4'd10) begin
                            cnt_q   <= 4'd0;
                            state_q <= StCheck;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else if (tmo_q >= TmoW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_q   <= '0;
                        cnt_q   <= 4'd0;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StCheck: begin
                    state_q <= StIdle;
                    if (shift_q[9] && (^shift_q[8:0])) begin
                        data_q     <= shift_q[7:0];
                        new_code_q <= 1'b1;
                        if (shift_q[7:0] == BREAK_CODE) begin
                            brk_q <= 1'b1;
                        end else if (brk_q) begin
                            led_q <= 1'b0;
                            brk_q <= 1'b0;
                        end else begin
                            led_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign LED      = led_q;
    assign data_out = data_q;
    assign new_code = new_code_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: table vectors, random frames against a
// key-state model, and hand sequences for latency, reset mid-frame and timeout.
module tb_ps2_keyboard_rx;

    logic       PS2_CLK  = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       CLK      = 1'b0;
    logic       reset    = 1'b1;
    logic       LED;
    logic [7:0] data_out;
    logic       new_code;

    always #1 CLK = ~CLK;

    ps2_keyboard_rx dut (
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA),
        .CLK      (CLK),
        .reset    (reset),
        .LED      (LED),
        .data_out (data_out),
        .new_code (new_code)
    );

    int   checks    = 0;
    int   failures  = 0;
    int   pulse_cnt = 0;
    int   dbl_cnt   = 0;
    logic prev_nc   = 1'b0;
    int   lat;

    always @(negedge CLK) begin
        if (new_code === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            if (prev_nc) dbl_cnt <= dbl_cnt + 1;
        end
        prev_nc <= (new_code === 1'b1);
    end

    // Key-state model: what the keyboard-decoding logic should see.
    logic [7:0] m_data = 8'h00;
    logic       m_led  = 1'b0;
    logic       m_brk  = 1'b0;

    function automatic logic frame_ok(logic [7:0] b, logic par, logic stop);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        ones += int'(par);
        return stop && (ones % 2 == 1);
    endfunction

    task automatic model_apply(input logic [7:0] b, input logic par, input logic stop);
        if (frame_ok(b, par, stop)) begin
            m_data = b;
            if (b == 8'hF0) m_brk = 1'b1;
            else if (m_brk) begin
                m_led = 1'b0;
                m_brk = 1'b0;
            end else m_led = 1'b1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends the first nbits bits of a frame; measures new_code latency on the stop edge.
    task automatic send(input logic [7:0] b, input logic par, input logic stop, input int nbits);
        logic [10:0] frame;
        frame = {stop, par, b, 1'b0};
        lat = 0;
        @(posedge CLK);
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = frame[i];
            #45 PS2_CLK = 1'b0;
            if (i == 10) begin
                for (int k = 1; k <= 8; k++) begin
                    @(posedge CLK);
                    @(negedge CLK);
                    if (lat == 0 && new_code === 1'b1) lat = k;
                end
                #34;
            end else begin
                #50;
            end
            PS2_CLK = 1'b1;
            #5;
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic do_frame(input string name, input logic [7:0] b, input logic par,
                            input logic stop, input int exp_pulse, input logic [7:0] exp_data,
                            input logic exp_led);
        int p0;
        p0 = pulse_cnt;
        send(b, par, stop, 11);
        #200;
        chk({name, "_pulses"}, pulse_cnt - p0, exp_pulse);
        chk({name, "_data"}, int'(data_out), int'(exp_data));
        chk({name, "_led"}, int'(LED), int'(exp_led));
        if (exp_pulse == 1) chk({name, "_latency"}, lat, 4);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       par;
        logic       stop;
        int         exp_pulse;
        logic [7:0] exp_data;
        logic       exp_led;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   p0;
        vecs[0] = '{8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b1};  // press
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 1, 8'hF0, 1'b1};  // break prefix
        vecs[2] = '{8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b0};  // release
        vecs[3] = '{8'h75, 1'b1, 1'b1, 0, 8'h75, 1'b0};  // bad parity
        vecs[4] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b1};
        vecs[5] = '{8'h1C, 1'b0, 1'b0, 0, 8'h1C, 1'b1};  // bad stop
        vecs[6] = '{8'hE0, 1'b0, 1'b1, 1, 8'hE0, 1'b1};
        vecs[7] = '{8'hF0, 1'b1, 1'b1, 1, 8'hF0, 1'b1};
        vecs[8] = '{8'hE0, 1'b0, 1'b1, 1, 8'hE0, 1'b0};

        repeat (5) @(posedge CLK);
        @(negedge CLK) reset = 1'b0;
        repeat (20) @(negedge CLK);
        chk("reset_led", int'(LED), 0);
        chk("reset_data", int'(data_out), 0);
        chk("reset_no_pulse", pulse_cnt, 0);

        for (int i = 0; i < 9; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].b, vecs[i].par, vecs[i].stop,
                     vecs[i].exp_pulse, vecs[i].exp_data, vecs[i].exp_led);
            model_apply(vecs[i].b, vecs[i].par, vecs[i].stop);
        end

        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            logic       par, stop;
            int         ep;
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b = 8'hF0;
            par = ~^b;
            if ($urandom_range(0, 4) == 0) par = ~par;
            stop = ($urandom_range(0, 7) != 0);
            ep = frame_ok(b, par, stop) ? 1 : 0;
            model_apply(b, par, stop);
            do_frame($sformatf("rnd%0d", i), b, par, stop, ep, m_data, m_led);
        end

        // Reset in the middle of a frame discards it.
        model_apply(8'h33, 1'b1, 1'b1);
        do_frame("pre_reset", 8'h33, 1'b1, 1'b1, 1, m_data, m_led);
        p0 = pulse_cnt;
        send(8'h5A, 1'b1, 1'b1, 5);
        reset = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK) reset = 1'b0;
        m_data = 8'h00;
        m_led  = 1'b0;
        m_brk  = 1'b0;
        #200;
        chk("midreset_pulses", pulse_cnt - p0, 0);
        chk("midreset_data", int'(data_out), 0);
        chk("midreset_led", int'(LED), 0);
        model_apply(8'h1C, 1'b0, 1'b1);
        do_frame("post_reset", 8'h1C, 1'b0, 1'b1, 1, m_data, m_led);

        // Partial frame stalls after bit 4 longer than the timeout.
        p0 = pulse_cnt;
        send(8'h6B, 1'b0, 1'b1, 5);
        #8400;
        chk("timeout_pulses", pulse_cnt - p0, 0);
        chk("timeout_data", int'(data_out), 8'h1C);
        model_apply(8'h29, 1'b0, 1'b1);
        do_frame("post_timeout", 8'h29, 1'b0, 1'b1, 1, m_data, m_led);

        chk("no_double_pulse", dbl_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
